// File: rtl/pipelined_multiplier_m.sv
// Fully pipelined RV32M/RV64M multiply unit (MUL/MULH/MULHSU/MULHU).
// Valid/ready in, valid/ready out, tag carried with every op, flush kills all.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   operation handshake
//   in_op               00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   in_a, in_b          rs1 / rs2 operands
//   in_tag              opaque tag returned with the result
//   flush               squash everything in flight and the op offered now
//   out_valid/out_ready result handshake
//   out_data, out_tag   selected product half and its tag
//   count, busy         number of occupied stages, count != 0
module pipelined_multiplier_m #(
    parameter int ARCH_LEN = 32,
    parameter int STAGES   = 5,
    parameter int TAG_W    = 6,
    localparam int CW      = $clog2(STAGES + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          in_op,
    input  logic [ARCH_LEN-1:0] in_a,
    input  logic [ARCH_LEN-1:0] in_b,
    input  logic [TAG_W-1:0]    in_tag,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ARCH_LEN-1:0] out_data,
    output logic [TAG_W-1:0]    out_tag,
    output logic [CW-1:0]       count,
    output logic                busy
);

    localparam int XW = ARCH_LEN + 1;
    localparam int PW = 2 * ARCH_LEN;

    logic [STAGES-1:0] v;
    logic [STAGES-1:0] en;
    logic              accept;
    logic              out_fire;

    // Stage k may move unless it and every stage after it are full
    // while the output is stalled; this is the unrolled ripple of
    // en[k] = !v[k] | en[k+1], without a self-referencing vector.
    always_comb begin
        en = '0;
        for (int k = 0; k < STAGES; k++) begin
            en[k] = out_ready
                  | ~&(v | ((STAGES'(1) << k) - STAGES'(1)));
        end
    end

    assign in_ready  = en[0] & ~flush;
    assign accept    = in_valid & in_ready;
    assign out_valid = v[STAGES-1] & ~flush;
    assign out_fire  = out_valid & out_ready;
    assign busy      = (count != '0);

    // Valid bits: the only state that needs reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v <= '0;
        end else if (flush) begin
            v <= '0;
        end else begin
            if (en[0]) begin
                v[0] <= accept;
            end
            for (int k = 1; k < STAGES; k++) begin
                if (en[k]) begin
                    v[k] <= v[k-1];
                end
            end
        end
    end

    // Occupancy counter kept alongside v so count is a plain register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            case ({accept, out_fire})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Operand extension: a signed for MULH/MULHSU, b signed for MULH.
    logic          a_sx;
    logic          b_sx;
    logic          hi;
    logic [XW-1:0] a_ext;
    logic [XW-1:0] b_ext;

    always_comb begin
        a_sx = 1'b0;
        b_sx = 1'b0;
        unique case (in_op)
            2'b01: begin
                a_sx = 1'b1;
                b_sx = 1'b1;
            end
            2'b10: a_sx = 1'b1;
            default: begin
                a_sx = 1'b0;
                b_sx = 1'b0;
            end
        endcase
        hi    = (in_op != 2'b00);
        a_ext = {a_sx & in_a[ARCH_LEN-1], in_a};
        b_ext = {b_sx & in_b[ARCH_LEN-1], in_b};
    end

    // Only the low 2*ARCH_LEN product bits are ever selected, and those
    // are identical for signed and unsigned multiplication once the
    // operands are sign-extended to that width.
    function automatic logic [ARCH_LEN-1:0] mul_sel(
        input logic [XW-1:0] a,
        input logic [XW-1:0] b,
        input logic          sel_hi
    );
        logic [PW-1:0] aw;
        logic [PW-1:0] bw;
        logic [PW-1:0] p;
        aw = {{(ARCH_LEN-1){a[XW-1]}}, a};
        bw = {{(ARCH_LEN-1){b[XW-1]}}, b};
        p  = aw * bw;
        return sel_hi ? p[PW-1:ARCH_LEN] : p[ARCH_LEN-1:0];
    endfunction

    // Tag travels with its op through every stage.
    logic [TAG_W-1:0] tag_q [STAGES];

    always_ff @(posedge clk) begin
        if (en[0]) begin
            tag_q[0] <= in_tag;
        end
        for (int k = 1; k < STAGES; k++) begin
            if (en[k]) begin
                tag_q[k] <= tag_q[k-1];
            end
        end
    end

    assign out_tag = tag_q[STAGES-1];

    generate
        if (STAGES == 1) begin : g_single
            logic [ARCH_LEN-1:0] res_q;

            always_ff @(posedge clk) begin
                if (en[0]) begin
                    res_q <= mul_sel(a_ext, b_ext, hi);
                end
            end

            assign out_data = res_q;
        end else begin : g_multi
            // Stage 0 registers operands so the multiplier sits between
            // two flops; later stages only carry the result.
            logic [XW-1:0]       a_q;
            logic [XW-1:0]       b_q;
            logic                hi_q;
            logic [ARCH_LEN-1:0] res_q [1:STAGES-1];

            always_ff @(posedge clk) begin
                if (en[0]) begin
                    a_q  <= a_ext;
                    b_q  <= b_ext;
                    hi_q <= hi;
                end
                if (en[1]) begin
                    res_q[1] <= mul_sel(a_q, b_q, hi_q);
                end
                for (int k = 2; k < STAGES; k++) begin
                    if (en[k]) begin
                        res_q[k] <= res_q[k-1];
                    end
                end
            end

            assign out_data = res_q[STAGES-1];
        end
    endgenerate

endmodule

// File: tb/tb_pipelined_multiplier_m.sv
// Scoreboard bench for pipelined_multiplier_m (32-bit/5-stage instance)
// plus a directed 64-bit/1-stage instance.
module tb_pipelined_multiplier_m;

    localparam int TW = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [TW-1:0] in_tag;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [TW-1:0] out_tag;
    logic [2:0]  count;
    logic        busy;

    logic        w_in_valid;
    logic        w_in_ready;
    logic [1:0]  w_in_op;
    logic [63:0] w_in_a;
    logic [63:0] w_in_b;
    logic [TW-1:0] w_in_tag;
    logic        w_flush;
    logic        w_out_valid;
    logic        w_out_ready;
    logic [63:0] w_out_data;
    logic [TW-1:0] w_out_tag;
    logic [0:0]  w_count;
    logic        w_busy;

    always #5 clk = ~clk;

    pipelined_multiplier_m #(.ARCH_LEN(32), .STAGES(5), .TAG_W(TW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag),
        .count(count), .busy(busy)
    );

    pipelined_multiplier_m #(.ARCH_LEN(64), .STAGES(1), .TAG_W(TW)) dut64 (
        .clk(clk), .rst(rst),
        .in_valid(w_in_valid), .in_ready(w_in_ready), .in_op(w_in_op),
        .in_a(w_in_a), .in_b(w_in_b), .in_tag(w_in_tag), .flush(w_flush),
        .out_valid(w_out_valid), .out_ready(w_out_ready),
        .out_data(w_out_data), .out_tag(w_out_tag),
        .count(w_count), .busy(w_busy)
    );

    typedef struct {
        logic [TW-1:0] tag;
        logic [31:0]   data;
        int            cyc;
    } exp_t;

    exp_t        q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    logic [31:0] exp_cur = '0;
    logic        lat_chk = 1'b0;
    logic        rnd_rdy = 1'b0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    logic [TW-1:0] prev_tag = '0;

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)",
                     name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic [127:0] pa;
        logic [127:0] pb;
        logic [127:0] p;
        pa = (op == 2'b01 || op == 2'b10) ? {{96{a[31]}}, a} : {96'b0, a};
        pb = (op == 2'b01) ? {{96{b[31]}}, b} : {96'b0, b};
        p  = pa * pb;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rnd_rdy) begin
            #1 out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Scoreboard monitor, sampled mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (!rst || flush) begin
            q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && out_valid) begin
                chk("hold_data", 64'(out_data), 64'(prev_data));
                chk("hold_tag", 64'(out_tag), 64'(prev_tag));
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_out_tag", 64'(out_tag), 64'hx);
                end else begin
                    e = q.pop_front();
                    chk("data", 64'(out_data), 64'(e.data));
                    chk("tag", 64'(out_tag), 64'(e.tag));
                    if (lat_chk) begin
                        chk("latency", 64'(cyc + 1 - e.cyc), 64'd5);
                    end
                end
            end
            if (in_valid && in_ready) begin
                q.push_back('{tag: in_tag, data: exp_cur, cyc: cyc + 1});
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_tag   = out_tag;
        end
    end

    task automatic send(input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [TW-1:0] tag,
                        input logic [31:0] exp, output int tries);
        logic acc;
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        exp_cur  = exp;
        acc      = 1'b0;
        tries    = 0;
        for (int i = 0; i < 64 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            tries++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!acc) chk("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic send_m(input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [TW-1:0] tag);
        int t;
        send(op, a, b, tag, model(op, a, b), t);
    endtask

    task automatic drain();
        int i;
        for (i = 0; i < 200; i++) begin
            if (q.size() == 0 && !out_valid) break;
            @(posedge clk);
            #1;
        end
        if (i == 200) chk("drain_timeout", 64'(q.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [1:0]  t2_op [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic [31:0] t2_a  [4] = '{32'hFFFFFFFF, 32'h80000000,
                               32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] t2_b  [4] = '{32'h00000002, 32'h80000000,
                               32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] t2_r  [4] = '{32'hFFFFFFFE, 32'h40000000,
                               32'hFFFFFFFF, 32'hFFFFFFFE};

    logic [1:0]  w_op [4] = '{2'b01, 2'b11, 2'b00, 2'b10};
    logic [63:0] w_a  [4] = '{64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF,
                              64'd3, 64'hFFFFFFFFFFFFFFFF};
    logic [63:0] w_b  [4] = '{64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF,
                              64'd5, 64'hFFFFFFFFFFFFFFFF};
    logic [63:0] w_r  [4] = '{64'h4000000000000000, 64'hFFFFFFFFFFFFFFFE,
                              64'd15, 64'hFFFFFFFFFFFFFFFF};

    initial begin
        int t;
        rst = 1'b0;
        in_valid = 1'b0;
        in_op = '0;
        in_a = '0;
        in_b = '0;
        in_tag = '0;
        flush = 1'b0;
        out_ready = 1'b1;
        w_in_valid = 1'b0;
        w_in_op = '0;
        w_in_a = '0;
        w_in_b = '0;
        w_in_tag = '0;
        w_flush = 1'b0;
        w_out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_w_out_valid", 64'(w_out_valid), 64'd0);
        rst = 1'b1;
        #1;
        chk("idle_in_ready", 64'(in_ready), 64'd1);

        // Asynchronous reset with ops in flight
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send_m(2'b00, 32'd7, 32'd9, 6'd1);
        send_m(2'b11, 32'd11, 32'd13, 6'd2);
        send_m(2'b01, 32'd17, 32'd19, 6'd3);
        repeat (5) @(posedge clk);
        #1;
        chk("pre_rst_out_valid", 64'(out_valid), 64'd1);
        chk("pre_rst_count", 64'(count), 64'd3);
        #2 rst = 1'b0;
        #1;
        chk("async_out_valid", 64'(out_valid), 64'd0);
        chk("async_count", 64'(count), 64'd0);
        chk("async_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        out_ready = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("post_rst_count", 64'(count), 64'd0);

        // Opcode coverage and back-to-back throughput, latency checked
        lat_chk = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(t2_op[i], t2_a[i], t2_b[i], 6'(10 + i), t2_r[i], t);
        end
        drain();
        for (int i = 0; i < 10; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = $urandom;
            b = $urandom;
            send(2'(i), a, b, 6'(20 + i), model(2'(i), a, b), t);
            chk("b2b_in_ready", 64'(t), 64'd1);
        end
        drain();
        lat_chk = 1'b0;

        // Backpressure with bubble collapse
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send_m(2'b01, $urandom, $urandom, 6'(30 + i));
            @(negedge clk);
            chk("bp_count", 64'(count), 64'(i + 1));
            chk("bp_in_ready", 64'(in_ready), (i < 4) ? 64'd1 : 64'd0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_op = 2'b11;
        in_a = 32'h12345678;
        in_b = 32'h9ABCDEF0;
        in_tag = 6'd40;
        exp_cur = model(2'b11, 32'h12345678, 32'h9ABCDEF0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            chk("stall_count", 64'(count), 64'd5);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", 64'(in_ready), 64'd1);
        chk("rel_out_valid", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("drain_out_valid", 64'(out_valid), 64'd1);
            @(posedge clk);
            #1;
        end
        drain();

        // Flush with ops in flight and one offered
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_m(2'b10, $urandom, $urandom, 6'(50 + i));
        repeat (3) @(posedge clk);
        #1;
        flush = 1'b1;
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_tag = 6'd55;
        #1;
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_busy", 64'(busy), 64'd0);
        repeat (15) @(posedge clk);
        #1;
        chk("flush_idle_count", 64'(count), 64'd0);

        // Random ops under random backpressure
        rnd_rdy = 1'b1;
        for (int i = 0; i < 30; i++) begin
            send_m(2'($urandom_range(0, 3)), $urandom, $urandom, 6'(i));
            if ($urandom_range(0, 2) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        rnd_rdy = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        drain();
        chk("final_count", 64'(count), 64'd0);

        // 64-bit, single stage: result the cycle after accept
        for (int i = 0; i < 4; i++) begin
            w_in_valid = 1'b1;
            w_in_op = w_op[i];
            w_in_a = w_a[i];
            w_in_b = w_b[i];
            w_in_tag = 6'(60 + i);
            @(negedge clk);
            chk("w_in_ready", 64'(w_in_ready), 64'd1);
            @(posedge clk);
            #1;
            chk("w_out_valid", 64'(w_out_valid), 64'd1);
            chk("w_data", w_out_data, w_r[i]);
            chk("w_tag", 64'(w_out_tag), 64'(60 + i));
        end
        w_in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("w_idle_valid", 64'(w_out_valid), 64'd0);
        chk("w_idle_count", 64'(w_count), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
